// File: rtl/control_fsm_if.sv
// Control FSM <-> datapath signal bundle: opcode and busy/flag inputs, control strobes out.
// Latency: none, wires only. Backpressure: IBUSYWAIT and DBUSYWAIT stall the FSM.
interface control_fsm_if #(
    parameter int OPW    = 8,
    parameter int ALUOPW = 3
);
    logic [OPW-1:0]    OPCODE;
    logic              IBUSYWAIT;
    logic              DBUSYWAIT;
    logic              ZERO;
    logic [ALUOPW-1:0] ALUOP;
    logic              WRITEENABLE;
    logic              SUBMUXSEL;
    logic              IMMUXSEL;
    logic              MEMREAD;
    logic              MEMWRITE;
    logic              WBMUXSEL;
    logic              PCENABLE;
    logic              PCSEL;
    logic              TRAP;

    modport master (
        output OPCODE, IBUSYWAIT, DBUSYWAIT, ZERO,
        input  ALUOP, WRITEENABLE, SUBMUXSEL, IMMUXSEL, MEMREAD, MEMWRITE,
               WBMUXSEL, PCENABLE, PCSEL, TRAP
    );

    modport slave (
        input  OPCODE, IBUSYWAIT, DBUSYWAIT, ZERO,
        output ALUOP, WRITEENABLE, SUBMUXSEL, IMMUXSEL, MEMREAD, MEMWRITE,
               WBMUXSEL, PCENABLE, PCSEL, TRAP
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT), one-hot, all outputs registered.
// Latency: ALU 4, j/beq 3, load 5+waits, store 4+waits cycles from FETCH back to FETCH.
// Backpressure: IBUSYWAIT holds FETCH; DBUSYWAIT holds MEM until it drops or TIMEOUT traps to HALT.
module control_fsm #(
    parameter int OPW     = 8,
    parameter int ALUOPW  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic           CLK,
    input  logic           RESET,
    control_fsm_if.slave   bus
);
    localparam logic [5:0] S_FETCH  = 6'b000001;
    localparam logic [5:0] S_DECODE = 6'b000010;
    localparam logic [5:0] S_EXEC   = 6'b000100;
    localparam logic [5:0] S_MEM    = 6'b001000;
    localparam logic [5:0] S_WB     = 6'b010000;
    localparam logic [5:0] S_HALT   = 6'b100000;
    localparam logic [7:0] TMO      = 8'(TIMEOUT);

    logic [5:0]        state_q, state_d;
    logic [OPW-1:0]    opcode_q, opcode_d;
    logic [7:0]        wait_q, wait_d, wait_inc;
    logic [ALUOPW-1:0] aluop_q, aluop_d;
    logic              sub_q, sub_d, imm_q, imm_d;
    logic              memread_q, memread_d, memwrite_q, memwrite_d;
    logic              we_q, we_d, pcen_q, pcen_d, pcsel_q, pcsel_d;
    logic              wbmux_q, wbmux_d, trap_q, trap_d;
    logic              go_halt;

    logic [ALUOPW-1:0] dec_aluop;
    logic              dec_sub, dec_imm, dec_legal;
    logic              op_alu, op_jump, op_beq, op_load, op_store;

    assign op_alu   = (opcode_q <= OPW'(5));
    assign op_jump  = (opcode_q == OPW'(6));
    assign op_beq   = (opcode_q == OPW'(7));
    assign op_load  = (opcode_q == OPW'(8))  || (opcode_q == OPW'(9));
    assign op_store = (opcode_q == OPW'(10)) || (opcode_q == OPW'(11));
    assign wait_inc = wait_q + 8'd1;

    always_comb begin
        dec_aluop = '0;
        dec_sub   = 1'b0;
        dec_imm   = 1'b0;
        dec_legal = 1'b1;
        case (opcode_q)
            OPW'(0):  dec_imm = 1'b1;
            OPW'(1):  ;
            OPW'(2):  dec_aluop = ALUOPW'(1);
            OPW'(3):  begin dec_aluop = ALUOPW'(1); dec_sub = 1'b1; end
            OPW'(4):  dec_aluop = ALUOPW'(2);
            OPW'(5):  dec_aluop = ALUOPW'(3);
            OPW'(6):  dec_aluop = ALUOPW'(1);
            OPW'(7):  begin dec_aluop = ALUOPW'(1); dec_sub = 1'b1; end
            OPW'(8):  dec_aluop = ALUOPW'(1);
            OPW'(9):  begin dec_aluop = ALUOPW'(1); dec_imm = 1'b1; end
            OPW'(10): dec_aluop = ALUOPW'(1);
            OPW'(11): begin dec_aluop = ALUOPW'(1); dec_imm = 1'b1; end
            default:  dec_legal = 1'b0;
        endcase
    end

    // Strobes (WE, PCEN, PCSEL, WBMUX) default low so each is a single-cycle pulse.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        wait_d     = wait_q;
        aluop_d    = aluop_q;
        sub_d      = sub_q;
        imm_d      = imm_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        we_d       = 1'b0;
        pcen_d     = 1'b0;
        pcsel_d    = 1'b0;
        wbmux_d    = 1'b0;
        trap_d     = trap_q;
        go_halt    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!bus.IBUSYWAIT) begin
                    opcode_d = bus.OPCODE;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    aluop_d = dec_aluop;
                    sub_d   = dec_sub;
                    imm_d   = dec_imm;
                    state_d = S_EXEC;
                end else begin
                    go_halt = 1'b1;
                end
            end
            S_EXEC: begin
                if (op_alu) begin
                    state_d = S_WB;
                    we_d    = 1'b1;
                    pcen_d  = 1'b1;
                end else if (op_jump || op_beq) begin
                    state_d = S_FETCH;
                    pcen_d  = 1'b1;
                    pcsel_d = op_jump | bus.ZERO;
                end else begin
                    state_d    = S_MEM;
                    wait_d     = '0;
                    memread_d  = op_load;
                    memwrite_d = op_store;
                end
            end
            S_MEM: begin
                if (!bus.DBUSYWAIT) begin
                    memread_d  = 1'b0;
                    memwrite_d = 1'b0;
                    pcen_d     = 1'b1;
                    if (op_load) begin
                        state_d = S_WB;
                        we_d    = 1'b1;
                        wbmux_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (wait_inc == TMO) begin
                    go_halt = 1'b1;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  ;
            default: go_halt = 1'b1;
        endcase
        if (go_halt) begin
            state_d    = S_HALT;
            trap_d     = 1'b1;
            aluop_d    = '0;
            sub_d      = 1'b0;
            imm_d      = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_FETCH;
            opcode_q   <= '0;
            wait_q     <= '0;
            aluop_q    <= '0;
            sub_q      <= 1'b0;
            imm_q      <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            we_q       <= 1'b0;
            pcen_q     <= 1'b0;
            pcsel_q    <= 1'b0;
            wbmux_q    <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            wait_q     <= wait_d;
            aluop_q    <= aluop_d;
            sub_q      <= sub_d;
            imm_q      <= imm_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            we_q       <= we_d;
            pcen_q     <= pcen_d;
            pcsel_q    <= pcsel_d;
            wbmux_q    <= wbmux_d;
            trap_q     <= trap_d;
        end
    end

    assign bus.ALUOP       = aluop_q;
    assign bus.SUBMUXSEL   = sub_q;
    assign bus.IMMUXSEL    = imm_q;
    assign bus.MEMREAD     = memread_q;
    assign bus.MEMWRITE    = memwrite_q;
    assign bus.WRITEENABLE = we_q;
    assign bus.PCENABLE    = pcen_q;
    assign bus.PCSEL       = pcsel_q;
    assign bus.WBMUXSEL    = wbmux_q;
    assign bus.TRAP        = trap_q;
endmodule
